counter_checker: RTL and testbench

- Synthesizable on-chip checker for the 4-bit loadable up/down counter.
- Sits on the receiving end of the counter bus (load, data_in, up_down, data_out) and mirrors what the monitor clocking block samples.
- Keeps its own reference model of the counter and compares it against data_out every cycle. Reports mismatches, a saturating error count, the first failing pair, and a sticky fail flag.
- Used in emulation and FPGA bring-up, where the SystemVerilog monitor is unavailable.

---
 rtl/counter_checker.sv | 125 ++++++++++++
 tb/tb_counter_checker.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/counter_checker.sv
// counter_checker: reference-model checker for the loadable up/down counter bus
module counter_checker #(
    parameter int WIDTH       = 4,
    parameter int ERR_W       = 8,
    parameter int FAIL_THRESH = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             up_down,
    input  logic [WIDTH-1:0] data_out,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [ERR_W-1:0] chk_count,
    output logic             first_valid,
    output logic [WIDTH-1:0] first_exp,
    output logic [WIDTH-1:0] first_act,
    output logic             fail
);
    typedef enum logic [1:0] {IDLE, CHECK, FAILED} state_t;
    localparam logic [ERR_W-1:0] THRESH = ERR_W'(FAIL_THRESH);
    state_t state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d, first_exp_q, first_exp_d, first_act_q, first_act_d;
    logic [ERR_W-1:0] consec_q, consec_d, err_count_q, err_count_d, chk_count_q, chk_count_d;
    logic mismatch_q, mismatch_d, first_valid_q, first_valid_d, fail_q, fail_d;
    logic [WIDTH-1:0] step_exp, step_obs;
    assign step_exp = load ? data_in : up_down ? exp_q + 1'b1 : exp_q - 1'b1;
    assign step_obs = load ? data_in : up_down ? data_out + 1'b1 : data_out - 1'b1;
    always_comb begin
        state_d       = state_q;
        exp_d         = exp_q;
        consec_d      = consec_q;
        mismatch_d    = 1'b0;
        err_count_d   = err_count_q;
        chk_count_d   = chk_count_q;
        first_valid_d = first_valid_q;
        first_exp_d   = first_exp_q;
        first_act_d   = first_act_q;
        fail_d        = fail_q;
        if (clear) begin
            state_d       = IDLE;
            exp_d         = '0;
            consec_d      = '0;
            err_count_d   = '0;
            chk_count_d   = '0;
            first_valid_d = 1'b0;
            first_exp_d   = '0;
            first_act_d   = '0;
            fail_d        = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        exp_d   = step_obs;
                        state_d = CHECK;
                    end
                end
                CHECK: begin
                    if (!enable) begin
                        state_d  = IDLE;
                        consec_d = '0;
                    end else begin
                        chk_count_d = &chk_count_q ? chk_count_q : chk_count_q + 1'b1;
                        if (data_out == exp_q) begin
                            consec_d = '0;
                            exp_d    = step_exp;
                        end else begin
                            // resync on the observed value so one glitch costs one error
                            mismatch_d  = 1'b1;
                            err_count_d = &err_count_q ? err_count_q : err_count_q + 1'b1;
                            consec_d    = consec_q + 1'b1;
                            exp_d       = step_obs;
                            if (!first_valid_q) begin
                                first_valid_d = 1'b1;
                                first_exp_d   = exp_q;
                                first_act_d   = data_out;
                            end
                            if (consec_q + 1'b1 == THRESH) begin
                                state_d = FAILED;
                                fail_d  = 1'b1;
                            end
                        end
                    end
                end
                FAILED: fail_d = 1'b1;
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            exp_q         <= '0;
            consec_q      <= '0;
            mismatch_q    <= 1'b0;
            err_count_q   <= '0;
            chk_count_q   <= '0;
            first_valid_q <= 1'b0;
            first_exp_q   <= '0;
            first_act_q   <= '0;
            fail_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            exp_q         <= exp_d;
            consec_q      <= consec_d;
            mismatch_q    <= mismatch_d;
            err_count_q   <= err_count_d;
            chk_count_q   <= chk_count_d;
            first_valid_q <= first_valid_d;
            first_exp_q   <= first_exp_d;
            first_act_q   <= first_act_d;
            fail_q        <= fail_d;
        end
    end
    assign mismatch    = mismatch_q;
    assign err_count   = err_count_q;
    assign chk_count   = chk_count_q;
    assign first_valid = first_valid_q;
    assign first_exp   = first_exp_q;
    assign first_act   = first_act_q;
    assign fail        = fail_q;
endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: random and directed checking of counter_checker against a behavioural model
module tb_counter_checker;
    logic clk = 0, reset = 1, enable = 0, clear = 0, load = 0, up_down = 0;
    logic [3:0] data_in = 0, data_out = 0;
    logic mis0, mis1, fv0, fv1, fl0, fl1;
    logic [7:0] err0, chk0;
    logic [1:0] err1, chk1;
    logic [3:0] fe0, fa0, fe1, fa1;
    int n_chk = 0, n_fail = 0;
    int cnt = 0;
    int m_st[2], m_exp[2], m_con[2], m_mis[2], m_err[2], m_chk[2], m_fv[2], m_fe[2], m_fa[2];
    int lim[2] = '{255, 3};

    always #5 clk = ~clk;

    counter_checker dut0 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
        .data_in(data_in), .up_down(up_down), .data_out(data_out),
        .mismatch(mis0), .err_count(err0), .chk_count(chk0), .first_valid(fv0),
        .first_exp(fe0), .first_act(fa0), .fail(fl0)
    );
    counter_checker #(.ERR_W(2)) dut1 (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear), .load(load),
        .data_in(data_in), .up_down(up_down), .data_out(data_out),
        .mismatch(mis1), .err_count(err1), .chk_count(chk1), .first_valid(fv1),
        .first_exp(fe1), .first_act(fa1), .fail(fl1)
    );

    task automatic check(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int nxt(input int v);
        return load ? int'(data_in) : up_down ? (v + 1) % 16 : (v + 15) % 16;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_st[k] = 0; m_exp[k] = 0; m_con[k] = 0; m_mis[k] = 0; m_err[k] = 0;
            m_chk[k] = 0; m_fv[k] = 0; m_fe[k] = 0; m_fa[k] = 0;
        end
    endtask

    // model states: 0 idle, 1 checking, 2 failed
    task automatic model_edge();
        int d = int'(data_out);
        for (int k = 0; k < 2; k++) begin
            m_mis[k] = 0;
            if (clear) begin
                m_st[k] = 0; m_con[k] = 0; m_err[k] = 0; m_chk[k] = 0;
                m_fv[k] = 0; m_fe[k] = 0; m_fa[k] = 0;
            end else if (m_st[k] == 0) begin
                if (enable) begin m_exp[k] = nxt(d); m_st[k] = 1; end
            end else if (m_st[k] == 1) begin
                if (!enable) begin
                    m_st[k] = 0; m_con[k] = 0;
                end else begin
                    if (m_chk[k] < lim[k]) m_chk[k]++;
                    if (d == m_exp[k]) begin
                        m_con[k] = 0; m_exp[k] = nxt(m_exp[k]);
                    end else begin
                        m_mis[k] = 1;
                        if (m_err[k] < lim[k]) m_err[k]++;
                        m_con[k]++;
                        if (m_fv[k] == 0) begin m_fv[k] = 1; m_fe[k] = m_exp[k]; m_fa[k] = d; end
                        m_exp[k] = nxt(d);
                        if (m_con[k] == 3) m_st[k] = 2;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        check("mismatch0", mis0, m_mis[0]);
        check("err_count0", err0, m_err[0]);
        check("chk_count0", chk0, m_chk[0]);
        check("first_valid0", fv0, m_fv[0]);
        check("first_exp0", fe0, m_fe[0]);
        check("first_act0", fa0, m_fa[0]);
        check("fail0", fl0, m_st[0] == 2 ? 1 : 0);
        check("mismatch1", mis1, m_mis[1]);
        check("err_count1", err1, m_err[1]);
        check("chk_count1", chk1, m_chk[1]);
        check("first_valid1", fv1, m_fv[1]);
        check("first_exp1", fe1, m_fe[1]);
        check("first_act1", fa1, m_fa[1]);
        check("fail1", fl1, m_st[1] == 2 ? 1 : 0);
    endtask

    // gl corrupts the counter's own state to gv before the edge
    task automatic step(input bit en, input bit cl, input bit ld, input int di,
                        input bit ud, input bit gl, input int gv);
        enable = en; clear = cl; load = ld; data_in = 4'(di); up_down = ud;
        if (gl) cnt = gv % 16;
        data_out = 4'(cnt);
        @(posedge clk);
        model_edge();
        cnt = nxt(cnt);
        #1 check_all();
    endtask

    task automatic pulse_reset();
        #2 reset = 1;
        #1 model_reset();
        check_all();
        check("rst_err0", err0, 0);
        check("rst_fail0", fl0, 0);
        #1 reset = 0;
    endtask

    initial begin
        #12 model_reset();
        check_all();
        #1 reset = 0;
        step(1, 0, 1, 14, 1, 0, 0);
        repeat (4) step(1, 0, 0, 0, 1, 0, 0);
        check("tp1_chk", chk0, 4);
        check("tp1_err", err0, 0);
        step(1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 1, 9);
        check("tp2_mis", mis0, 1);
        check("tp2_err", err0, 1);
        check("tp2_fexp", fe0, 15);
        check("tp2_fact", fa0, 9);
        step(1, 0, 0, 0, 0, 0, 0);
        check("tp2_resync", mis0, 0);
        step(0, 1, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        repeat (3) step(1, 0, 0, 0, 1, 1, cnt + 8);
        check("tp3_fail", fl0, 1);
        check("tp3_err", err0, 3);
        repeat (2) step(1, 0, 0, 0, 1, 1, cnt + 8);
        check("tp3_frozen", err0, 3);
        step(1, 1, 0, 0, 1, 0, 0);
        check("tp5_fail", fl0, 0);
        check("tp5_err", err0, 0);
        check("tp5_fv", fv0, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        check("tp5_seed", chk0, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        check("tp5_cmp", chk0, 1);
        step(0, 0, 1, 7, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        check("tp4_seed", mis0, 0);
        step(0, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 1, 0, 0);
        check("tp4_err", err0, 0);
        check("tp4_chk", chk0, 3);
        for (int i = 0; i < 6; i++) begin
            step(1, 0, 0, 0, 1, 1, cnt + 3);
            step(1, 0, 0, 0, 1, 0, 0);
        end
        check("tp6_sat", err1, 3);
        check("tp6_wide", err0, 6);
        pulse_reset();
        repeat (400) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 7) == 0,
                 int'($urandom_range(0, 15)), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 4) == 0, int'($urandom_range(0, 15)));
            if ($urandom_range(0, 99) == 0) pulse_reset();
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
